// File: rtl/float_to_int_converter.sv
// Pipelined FP32 -> signed OUT_WIDTH-bit integer converter (4 stages, 2-bit status).
// Optional macro ROUND_NEAREST_EN: round to nearest-even instead of truncating toward zero.

package float_struct;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;
endpackage

module float_to_int_converter
    import float_struct::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int STAGES    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  float_point_num              a,
    input  logic                        arg_vld,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        res_vld,
    output logic [1:0]                  res_state
);

    localparam int MAG_W = OUT_WIDTH + 1;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAN = 2'b01;
    localparam logic [1:0] ST_INF = 2'b10;
    localparam logic [1:0] ST_NUL = 2'b11;
    localparam logic signed [8:0] EMAX    = 9'(OUT_WIDTH - 1);
    localparam logic [MAG_W-1:0]  POS_LIM = {2'b00, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [MAG_W-1:0]  NEG_LIM = {2'b01, {(OUT_WIDTH-1){1'b0}}};

    if (STAGES != 4) begin : g_bad_stages
        $error("float_to_int_converter: STAGES must be 4");
    end
    if (OUT_WIDTH < 8 || OUT_WIDTH > 32) begin : g_bad_width
        $error("float_to_int_converter: OUT_WIDTH must be in 8..32");
    end

`ifdef ROUND_NEAREST_EN
    function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] mag,
                                                   input logic guard,
                                                   input logic sticky);
        return mag + MAG_W'(guard & (sticky | mag[0]));
    endfunction
`endif

    // Returns {state, value}; precedence NAN > INF > NUL > OK.
    function automatic logic [OUT_WIDTH+1:0] saturate(input logic sign,
                                                      input logic big,
                                                      input logic nan,
                                                      input logic [MAG_W-1:0] mag);
        logic [OUT_WIDTH-1:0] val;
        logic [1:0]           st;
        if (nan) begin
            val = '0;
            st  = ST_NAN;
        end else if (big || (sign ? (mag > NEG_LIM) : (mag > POS_LIM))) begin
            val = sign ? NEG_LIM[OUT_WIDTH-1:0] : POS_LIM[OUT_WIDTH-1:0];
            st  = ST_INF;
        end else begin
            val = sign ? -mag[OUT_WIDTH-1:0] : mag[OUT_WIDTH-1:0];
            st  = (val == '0) ? ST_NUL : ST_OK;
        end
        return {st, val};
    endfunction

    logic                    vld_p1, vld_p2, vld_p3;
    logic                    sign_p1, nan_p1, inf_p1, zero_p1;
    logic [7:0]              exp_p1;
    logic [22:0]             mant_p1;
    logic                    sign_p2, nan_p2, zero_p2, big_p2, neg_p2;
    logic [23:0]             sig_p2;
    logic signed [8:0]       e_p2;
    logic signed [8:0]       e_c;
    logic                    sign_p3, nan_p3, big_p3;
    logic [MAG_W-1:0]        mag_p3, mag_c, mag_fin;
    logic [5:0]              shl, shr;
    logic [OUT_WIDTH+1:0]    fin;
`ifdef ROUND_NEAREST_EN
    logic                    guard_c, sticky_c, guard_p3, sticky_p3;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p1 <= arg_vld;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // S1: capture and classify
    always_ff @(posedge clk) begin
        sign_p1 <= a.sign;
        exp_p1  <= a.exp;
        mant_p1 <= a.mant;
        nan_p1  <= (a.exp == 8'hFF) && (a.mant != '0);
        inf_p1  <= (a.exp == 8'hFF) && (a.mant == '0);
        zero_p1 <= (a.exp == 8'h00);
    end

    // S2: unbias exponent, restore hidden bit
    assign e_c = $signed({1'b0, exp_p1}) - 9'sd127;

    always_ff @(posedge clk) begin
        sign_p2 <= sign_p1;
        nan_p2  <= nan_p1;
        zero_p2 <= zero_p1;
        sig_p2  <= {1'b1, mant_p1};
        e_p2    <= e_c;
        big_p2  <= inf_p1 | (e_c > EMAX);
        neg_p2  <= e_c[8];
    end

    // S3: align significand to the integer binary point
    always_comb begin
        shl   = '0;
        shr   = '0;
        mag_c = '0;
`ifdef ROUND_NEAREST_EN
        guard_c  = 1'b0;
        sticky_c = 1'b0;
`endif
        if (zero_p2 || big_p2 || nan_p2) begin
            mag_c = '0;
        end else if (neg_p2) begin
`ifdef ROUND_NEAREST_EN
            guard_c  = (e_p2 == -9'sd1);
            sticky_c = guard_c ? (|sig_p2[22:0]) : 1'b1;
`endif
        end else if (e_p2 >= 9'sd23) begin
            shl   = e_p2[5:0] - 6'd23;
            mag_c = MAG_W'({40'd0, sig_p2} << shl);
        end else begin
            shr   = 6'd23 - e_p2[5:0];
            mag_c = MAG_W'({40'd0, sig_p2} >> shr);
`ifdef ROUND_NEAREST_EN
            guard_c  = |(sig_p2 & (24'd1 << (shr - 6'd1)));
            sticky_c = |(sig_p2 & ((24'd1 << (shr - 6'd1)) - 24'd1));
`endif
        end
    end

    always_ff @(posedge clk) begin
        sign_p3 <= sign_p2;
        nan_p3  <= nan_p2;
        big_p3  <= big_p2;
        mag_p3  <= mag_c;
`ifdef ROUND_NEAREST_EN
        guard_p3  <= guard_c;
        sticky_p3 <= sticky_c;
`endif
    end

    // S4: round, range check, negate
    always_comb begin
`ifdef ROUND_NEAREST_EN
        mag_fin = round_mag(mag_p3, guard_p3, sticky_p3);
`else
        mag_fin = mag_p3;
`endif
        fin = saturate(sign_p3, big_p3, nan_p3, mag_fin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld   <= 1'b0;
            result    <= '0;
            res_state <= ST_OK;
        end else begin
            res_vld <= vld_p3;
            if (vld_p3) begin
                result    <= $signed(fin[OUT_WIDTH-1:0]);
                res_state <= fin[OUT_WIDTH+1:OUT_WIDTH];
            end
        end
    end

endmodule
